bus_host_arbiter: RTL and testbench

- Shares a single device-side request port between NrHosts bus hosts, for example the core data port plus a DMA or debug host, in front of the system RAM or the bus.
- Arbitrates round-robin and issues one grant per cycle at most.
- Tracks outstanding transactions in an in-order ID FIFO, so each response (rvalid/rdata/err) is returned to the host that issued the request.
- Uses the same req/gnt/rvalid protocol as the core LSU interface on both sides.

---
 rtl/bus_host_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_host_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between NrHosts hosts,
// with an in-order ID FIFO for response routing. Define ARB_TIMEOUT_EN for response timeouts.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic                              spurious_rsp_o
);
    localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int BeW  = DataWidth / 8;

    if (NrHosts < 2 || NrHosts > 8 || MaxOutstanding < 1 || MaxOutstanding > 8 ||
        TimeoutCycles < 2) begin : g_bad_params
        $error("bus_host_arbiter: parameter out of range");
    end

    logic [IdW-1:0]  fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic [IdW-1:0]  last_q;
    logic            spurious_q;

    logic [IdW-1:0]  winner;
    logic            has_winner, push, pop, rsp_real, rsp_spur, timeout;
    int              idx;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan from lowest to highest priority so the last hit (last_q+1) wins.
    always_comb begin
        winner     = '0;
        has_winner = 1'b0;
        idx        = 0;
        for (int i = NrHosts; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NrHosts;
            if (host_req_i[idx]) begin
                has_winner = 1'b1;
                winner     = IdW'(idx);
            end
        end
    end

    assign dev_req_o   = !rst_i && (|host_req_i) && (count_q != CntW'(MaxOutstanding));
    assign push        = dev_req_o && dev_gnt_i;
    assign dev_addr_o  = has_winner ? host_addr_i[int'(winner)*AddressWidth +: AddressWidth] : '0;
    assign dev_we_o    = has_winner ? host_we_i[winner] : 1'b0;
    assign dev_be_o    = has_winner ? host_be_i[int'(winner)*BeW +: BeW] : '0;
    assign dev_wdata_o = has_winner ? host_wdata_i[int'(winner)*DataWidth +: DataWidth] : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int TmrW = $clog2(TimeoutCycles);
    logic [TmrW-1:0] tmr_q;
    logic [CntW-1:0] orphan_q;
    logic            rsp_orphan;

    // Responses to timed-out requests still arrive first, so they are absorbed here.
    assign rsp_orphan = dev_rvalid_i && (orphan_q != '0);
    assign rsp_real   = dev_rvalid_i && (orphan_q == '0) && (count_q != '0);
    assign rsp_spur   = dev_rvalid_i && (orphan_q == '0) && (count_q == '0);
    assign timeout    = !rst_i && (count_q != '0) && (tmr_q == TmrW'(TimeoutCycles - 1)) && !rsp_real;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q    <= '0;
            orphan_q <= '0;
        end else begin
            tmr_q <= (count_q == '0 || pop) ? '0 : tmr_q + 1'b1;
            if (timeout && !rsp_orphan && orphan_q != '1)
                orphan_q <= orphan_q + 1'b1;
            else if (rsp_orphan && !timeout)
                orphan_q <= orphan_q - 1'b1;
        end
    end
`else
    assign rsp_real = dev_rvalid_i && (count_q != '0);
    assign rsp_spur = dev_rvalid_i && (count_q == '0);
    assign timeout  = 1'b0;
`endif

    assign pop          = !rst_i && (rsp_real || timeout);
    assign host_rdata_o = timeout ? '0 : dev_rdata_i;
    assign host_err_o   = pop && (timeout || dev_err_i);

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        if (push) host_gnt_o[winner] = 1'b1;
        if (pop)  host_rvalid_o[fifo_q[rptr_q]] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            last_q     <= IdW'(NrHosts - 1);
            spurious_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= winner;
                wptr_q         <= ptr_inc(wptr_q);
                last_q         <= winner;
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (rsp_spur) spurious_q <= 1'b1;
        end
    end

    assign spurious_rsp_o = spurious_q;
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Scoreboard bench for bus_host_arbiter (2 hosts, 2 outstanding); expected grants and
// response routing come from a queue model updated as stimulus is driven.
module tb_bus_host_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  host_req_i = '0, host_gnt_o, host_rvalid_o, hwe = '0;
    logic [31:0] haddr [2];
    logic [3:0]  hbe [2];
    logic [31:0] hwdata [2];
    logic [31:0] host_rdata_o, dev_addr_o, dev_wdata_o, dev_rdata_i = '0;
    logic        host_err_o, dev_req_o, dev_gnt_i = 1'b0, dev_we_o;
    logic [3:0]  dev_be_o;
    logic        dev_rvalid_i = 1'b0, dev_err_i = 1'b0, spurious_rsp_o;

    int n_tests = 0, n_fail = 0;
    int m_q[$];
    int m_last = 1;
    bit m_spur = 1'b0;
    bit fix_data = 1'b0;

    always #5 clk_i = ~clk_i;

    bus_host_arbiter #(.NrHosts(2), .DataWidth(32), .AddressWidth(32),
                       .MaxOutstanding(2), .TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i({haddr[1], haddr[0]}), .host_we_i(hwe),
        .host_be_i({hbe[1], hbe[0]}), .host_wdata_i({hwdata[1], hwdata[0]}),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o),
        .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
        .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
        .spurious_rsp_o(spurious_rsp_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] req, input bit gnt, input bit rv,
                         input logic [31:0] rdata, input bit err);
        host_req_i   = req;
        dev_gnt_i    = gnt;
        dev_rvalid_i = rv;
        dev_rdata_i  = rdata;
        dev_err_i    = err;
        if (!fix_data) begin
            for (int h = 0; h < 2; h++) begin
                haddr[h]  = $urandom;
                hbe[h]    = 4'($urandom);
                hwdata[h] = $urandom;
                hwe[h]    = 1'($urandom);
            end
        end
    endtask

    // One clock of stimulus; compares all outputs against the model, then advances it.
    task automatic cyc(input logic [1:0] req, input bit gnt, input bit rv,
                       input logic [31:0] rdata, input bit err);
        int  w;
        bit  has, exp_req;
        logic [1:0] exp_gnt, exp_rv;
        @(posedge clk_i); #1;
        drive(req, gnt, rv, rdata, err);
        #4;
        has = (req != 2'b00);
        w   = req[(m_last + 1) % 2] ? (m_last + 1) % 2 : m_last;
        exp_req = has && (m_q.size() < 2);
        exp_gnt = (exp_req && gnt) ? 2'(1 << w) : 2'b00;
        exp_rv  = (rv && m_q.size() > 0) ? 2'(1 << m_q[0]) : 2'b00;
        check("spurious", 64'(spurious_rsp_o), 64'(m_spur));
        check("dev_req", 64'(dev_req_o), 64'(exp_req));
        check("gnt", 64'(host_gnt_o), 64'(exp_gnt));
        check("dev_addr", 64'(dev_addr_o), has ? 64'(haddr[w]) : 64'd0);
        check("dev_we", 64'(dev_we_o), has ? 64'(hwe[w]) : 64'd0);
        check("dev_be", 64'(dev_be_o), has ? 64'(hbe[w]) : 64'd0);
        check("dev_wdata", 64'(dev_wdata_o), has ? 64'(hwdata[w]) : 64'd0);
        check("rvalid", 64'(host_rvalid_o), 64'(exp_rv));
        if (exp_rv != 2'b00) begin
            check("rdata", 64'(host_rdata_o), 64'(rdata));
            check("err", 64'(host_err_o), 64'(err));
        end
        if (rv && m_q.size() == 0) m_spur = 1'b1;
        if (rv && m_q.size() > 0) void'(m_q.pop_front());
        if (exp_gnt != 2'b00) begin
            m_q.push_back(w);
            m_last = w;
        end
    endtask

    task automatic do_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i); #1;
            rst_i = 1'b1;
            drive(2'b11, 1'b1, 1'b1, 32'hA5A5_0000 + 32'(c), 1'b1);
            #4;
            check("rst_gnt", 64'(host_gnt_o), 64'd0);
            check("rst_rvalid", 64'(host_rvalid_o), 64'd0);
            check("rst_req", 64'(dev_req_o), 64'd0);
            check("rst_err", 64'(host_err_o), 64'd0);
            check("rst_rdata", 64'(host_rdata_o), 64'h0000_0000_A5A5_0000 + 64'(c));
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        #4;
        check("rst_spur", 64'(spurious_rsp_o), 64'd0);
        check("rst_idle_req", 64'(dev_req_o), 64'd0);
        m_q.delete();
        m_last = 1;
        m_spur = 1'b0;
    endtask

    initial begin
        for (int h = 0; h < 2; h++) begin
            haddr[h] = '0; hbe[h] = '0; hwdata[h] = '0;
        end
        do_reset();

        // Both hosts request continuously, responses one cycle after each grant.
        for (int i = 0; i < 10; i++) cyc(2'b11, 1'b1, i > 0, 32'h100 + 32'(i), 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'h1FF, 1'b1);

        // Host 1 alone with fixed payload; first cycle the device withholds its grant.
        fix_data  = 1'b1;
        haddr[0]  = 32'h1111_1111; hbe[0] = 4'h3; hwdata[0] = 32'h2222_2222; hwe = 2'b10;
        haddr[1]  = 32'h0010_0040; hbe[1] = 4'hF; hwdata[1] = 32'hDEAD_BEEF;
        cyc(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'hCAFE, 1'b0);
        fix_data = 1'b0;

        // Fill to MaxOutstanding, then a response frees a slot for the next cycle.
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b11, 1'b1, 1'b1, 32'h1234, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'h55, 1'b1);
        cyc(2'b00, 1'b0, 1'b1, 32'h66, 1'b0);

        // Random traffic; a forced response every 4th cycle keeps waits short.
        for (int i = 0; i < 40; i++)
            cyc(2'($urandom), 1'($urandom), (i % 4 == 3) || 1'($urandom), $urandom, 1'($urandom));
        while (m_q.size() > 0) cyc(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        // Spurious response sticks until reset.
        do_reset();
        cyc(2'b00, 1'b0, 1'b1, 32'h9, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset with two outstanding, then old responses are spurious.
        do_reset();
        cyc(2'b00, 1'b0, 1'b1, 32'h7, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'h8, 1'b0);

`ifdef ARB_TIMEOUT_EN
        do_reset();
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_i); #1;
            drive(2'b00, 1'b0, 1'b0, 32'hF00D_0000 | 32'(k), 1'b0);
            #4;
            check("to_rvalid", 64'(host_rvalid_o), (k == 16) ? 64'd1 : 64'd0);
            if (k == 16) begin
                check("to_err", 64'(host_err_o), 64'd1);
                check("to_rdata", 64'(host_rdata_o), 64'd0);
            end
        end
        void'(m_q.pop_front());
        @(posedge clk_i); #1;
        drive(2'b00, 1'b0, 1'b1, 32'hBAD, 1'b0);
        #4;
        check("orphan_drop", 64'(host_rvalid_o), 64'd0);
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 32'h77, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
